whack_game_core: RTL and testbench

//  Clocked, parametrised whack-a-mole game engine for N holes. Pops one mole at a

---
 rtl/wam_pkg.sv | 6 +
 rtl/mole_lfsr.sv | 14 +
 rtl/whack_game_core.sv | 127 ++++++++++++
 tb/tb_whack_game_core.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/wam_pkg.sv
// wam_pkg: shared state encoding and LFSR constants for the whack-a-mole core
package wam_pkg;
  typedef enum logic [2:0] {IDLE, SPAWN, UP, GAP, OVER} state_t;
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
endpackage

// File: rtl/mole_lfsr.sv
// mole_lfsr: free-running 16-bit Galois LFSR (taps 16,14,13,11) with sync seed load
module mole_lfsr
  import wam_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] lfsr
);
  always_ff @(posedge clk)
    if (reset) lfsr <= SEED;
    else       lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0);
endmodule

// File: rtl/whack_game_core.sv
// whack_game_core: N-hole whack-a-mole engine; define WAM_SPEEDUP_EN to shrink the window as score grows
module whack_game_core
  import wam_pkg::*;
#(
  parameter int          N_HOLES      = 4,
  parameter int          SCORE_W      = 4,
  parameter int          UP_CYCLES    = 1000,
  parameter int          GAP_CYCLES   = 200,
  parameter int          MAX_MISSES   = 3,
  parameter logic [15:0] LFSR_SEED    = DEFAULT_SEED,
  parameter int          SPEEDUP_STEP = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [N_HOLES-1:0]                btn,
  output logic [N_HOLES-1:0]                mole,
  output logic [SCORE_W-1:0]                score,
  output logic [$clog2(MAX_MISSES+1)-1:0]   misses,
  output logic                              hit_pulse,
  output logic                              cheat_pulse,
  output logic                              game_over
);
  localparam int MW   = $clog2(MAX_MISSES + 1);
  localparam int HW   = $clog2(N_HOLES);
  localparam int TMAX = UP_CYCLES > GAP_CYCLES ? UP_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX);
  localparam logic [MW-1:0]      MISS_MAX = MW'(MAX_MISSES);
  localparam logic [N_HOLES-1:0] ONE      = 1;
  localparam logic [TW-1:0]      GAP_LOAD = TW'(GAP_CYCLES - 1);
  state_t              state, state_n;
  logic [15:0]         lfsr;
  logic [N_HOLES-1:0]  btn_q, rise, mole_n;
  logic [SCORE_W-1:0]  score_n;
  logic [MW-1:0]       misses_n, miss_inc;
  logic [HW-1:0]       last_hole, last_n, hole_raw, hole;
  logic [TW-1:0]       timer, timer_n;
  logic [31:0]         window;
  logic                hit_n, cheat_n, unused_bits;
  mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .reset(reset), .lfsr(lfsr));
  assign rise        = btn & ~btn_q;
  assign miss_inc    = (misses == MISS_MAX) ? misses : misses + 1'b1;
  assign hole_raw    = HW'(32'(lfsr[7:0]) % N_HOLES);
  assign hole        = (hole_raw != last_hole) ? hole_raw :
                       (hole_raw == HW'(N_HOLES - 1)) ? '0 : hole_raw + 1'b1;
  assign game_over   = state == OVER;
  assign unused_bits = ^{lfsr[15:8], SPEEDUP_STEP};
`ifdef WAM_SPEEDUP_EN
  logic [31:0] dec;
  assign dec    = 32'(score) * 32'(SPEEDUP_STEP);
  assign window = (dec > 32'(UP_CYCLES - UP_CYCLES / 4)) ? 32'(UP_CYCLES / 4) : 32'(UP_CYCLES) - dec;
`else
  assign window = 32'(UP_CYCLES);
`endif
  always_comb begin
    state_n  = state;
    mole_n   = mole;
    score_n  = score;
    misses_n = misses;
    last_n   = last_hole;
    timer_n  = timer;
    hit_n    = 1'b0;
    cheat_n  = 1'b0;
    case (state)
      IDLE, OVER: if (start) begin
        score_n  = '0;
        misses_n = '0;
        state_n  = SPAWN;
      end
      SPAWN: begin
        mole_n  = ONE << hole;
        last_n  = hole;
        timer_n = TW'(window - 32'd1);
        state_n = UP;
      end
      UP: begin
        timer_n = timer - 1'b1;
        // a stray bit outside the lit hole outranks a correct press in the same cycle
        if (|(rise & ~mole)) begin
          cheat_n  = 1'b1;
          misses_n = miss_inc;
        end else if (rise == mole) begin
          hit_n   = 1'b1;
          score_n = (&score) ? score : score + 1'b1;
        end else if (timer == '0) begin
          misses_n = miss_inc;
        end
        if (cheat_n || hit_n || timer == '0) begin
          mole_n  = '0;
          timer_n = GAP_LOAD;
          state_n = (misses_n == MISS_MAX) ? OVER : GAP;
        end
      end
      GAP: begin
        timer_n = timer - 1'b1;
        if (|rise) begin
          cheat_n  = 1'b1;
          misses_n = miss_inc;
        end
        state_n = (|rise && miss_inc == MISS_MAX) ? OVER : (timer == '0) ? SPAWN : GAP;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    btn_q <= reset ? '0 : btn;
    if (reset) begin
      state       <= IDLE;
      mole        <= '0;
      score       <= '0;
      misses      <= '0;
      last_hole   <= '0;
      timer       <= '0;
      hit_pulse   <= 1'b0;
      cheat_pulse <= 1'b0;
    end else begin
      state       <= state_n;
      mole        <= mole_n;
      score       <= score_n;
      misses      <= misses_n;
      last_hole   <= last_n;
      timer       <= timer_n;
      hit_pulse   <= hit_n;
      cheat_pulse <= cheat_n;
    end
  end
endmodule

// File: tb/tb_whack_game_core.sv
// tb_whack_game_core: directed checks of hits, cheats, timeouts, saturation and reset
module tb_whack_game_core;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] btn = '0;
  logic [3:0] mole;
  logic [3:0] score;
  logic [1:0] misses;
  logic       hit_pulse, cheat_pulse, game_over;
  logic [3:0] prev_mole, wrong;
  int         n_chk = 0;
  int         n_pass = 0;
  int         n;
  whack_game_core #(
    .N_HOLES(4), .SCORE_W(4), .UP_CYCLES(8), .GAP_CYCLES(4), .MAX_MISSES(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .btn(btn), .mole(mole), .score(score),
    .misses(misses), .hit_pulse(hit_pulse), .cheat_pulse(cheat_pulse), .game_over(game_over)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic wait_mole();
    int w = 0;
    while (mole == '0 && w < 30) begin
      tick(1);
      w++;
    end
    check("mole_appears", 32'(w < 30), 1);
    check("mole_onehot", $countones(mole), 1);
    check("no_repeat", 32'(mole == prev_mole), 0);
    prev_mole = mole;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    tick(2);
    check("rst_mole", mole, 0);
    check("rst_score", score, 0);
    check("rst_misses", misses, 0);
    check("rst_over", game_over, 0);
    check("rst_pulses", {hit_pulse, cheat_pulse}, 0);
    reset = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    check("first_hole", mole, 4'b0010);
    prev_mole = mole;
    tick(2);
    btn = mole;
    tick(1);
    check("hit_pulse", hit_pulse, 1);
    check("hit_score", score, 1);
    check("hit_mole_off", mole, 0);
    check("hit_no_cheat", cheat_pulse, 0);
    tick(1);
    check("hit_once", hit_pulse, 0);
    wait_mole();
    tick(1);
    check("held_score", score, 1);
    check("held_no_cheat", cheat_pulse, 0);
    btn = '0;
    tick(1);
    wrong = (mole == 4'b0001) ? 4'b0100 : 4'b0001;
    btn = mole | wrong;
    tick(1);
    check("both_cheat", cheat_pulse, 1);
    check("both_no_hit", hit_pulse, 0);
    check("both_misses", misses, 1);
    check("both_score", score, 1);
    check("both_mole_off", mole, 0);
    btn = '0;
    wait_mole();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("midup_mole", mole, 0);
    check("midup_score", score, 0);
    check("midup_misses", misses, 0);
    tick(3);
    check("idle_mole", mole, 0);
    check("idle_over", game_over, 0);
    prev_mole = 4'b0001;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      wait_mole();
      n = 0;
      while (mole != '0 && n < 20) begin
        n++;
        tick(1);
      end
      check("up_len", n, 8);
      check("timeout_misses", misses, k);
      check("timeout_no_cheat", cheat_pulse, 0);
    end
    check("over_flag", game_over, 1);
    check("over_mole", mole, 0);
    tick(5);
    check("over_frozen_misses", misses, 3);
    check("over_held", game_over, 1);
    check("over_mole_dark", mole, 0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("restart_score", score, 0);
    check("restart_misses", misses, 0);
    check("restart_over", game_over, 0);
    for (int i = 1; i <= 17; i++) begin
      wait_mole();
      btn = mole;
      tick(1);
      check("sat_hit_pulse", hit_pulse, 1);
      check("sat_score", score, (i > 15) ? 15 : i);
      btn = '0;
      tick(1);
    end
    check("sat_final", score, 15);
    check("sat_misses", misses, 0);
    btn = 4'b0001;
    tick(1);
    check("gap_cheat", cheat_pulse, 1);
    check("gap_misses", misses, 1);
    check("gap_score", score, 15);
    btn = '0;
    tick(2);
    check("gap_still_dark", mole, 0);
    tick(1);
    check("gap_no_restart", 32'(mole != '0), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
